drysponge_mix_ctrl: RTL and testbench

- Sequencer for the DrySponge MixPhase around the mix32 XOR datapath and the GASCON core-round engine.
- Accepts one input block plus its domain-separation bits and walks them in 2*CW-bit chunks, lowest chunk first.
- For each chunk it drives the mix32 word-select vector with a one-cycle mix strobe, then requests one core round, for every chunk except the last.
- Sits between the DrySponge top-level FSM and the state register / round engine.

---
 rtl/drysponge_mix_ctrl_if.sv | 34 +++
 rtl/drysponge_mix_ctrl.sv | 142 ++++++++++++++
 tb/tb_drysponge_mix_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drysponge_mix_ctrl_if.sv
// Handshake/control bundle between the DrySponge top FSM + round engine (master)
// and the MixPhase sequencer (slave).
interface drysponge_mix_ctrl_if #(
  parameter int unsigned CW         = 5,
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned DS_BITS    = 4
);
  localparam int unsigned CHW    = 2 * CW;
  localparam int unsigned NCHUNK = (BLOCK_BITS + DS_BITS + CHW - 1) / CHW;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic                  blk_valid;
  logic                  blk_ready;
  logic [BLOCK_BITS-1:0] blk_data;
  logic [DS_BITS-1:0]    blk_ds;
  logic [CHW-1:0]        mix_d;
  logic                  mix_en;
  logic                  round_req;
  logic                  round_ack;
  logic                  busy;
  logic                  done;
  logic [IW-1:0]         chunk_idx;
  logic                  abort;

  modport master (
    output blk_valid, blk_data, blk_ds, round_ack, abort,
    input  blk_ready, mix_d, mix_en, round_req, busy, done, chunk_idx
  );

  modport slave (
    input  blk_valid, blk_data, blk_ds, round_ack, abort,
    output blk_ready, mix_d, mix_en, round_req, busy, done, chunk_idx
  );
endinterface

// File: rtl/drysponge_mix_ctrl.sv
// DrySponge MixPhase sequencer: walks {pad, ds, block} in 2*CW-bit chunks, one mix
// strobe per chunk and one core round between chunks. Optional abort: MIX_CTRL_ABORT_EN.
module drysponge_mix_ctrl #(
  parameter int unsigned CW         = 5,
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned DS_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  drysponge_mix_ctrl_if.slave  bus
);
  localparam int unsigned CHW    = 2 * CW;
  localparam int unsigned NCHUNK = (BLOCK_BITS + DS_BITS + CHW - 1) / CHW;
  localparam int unsigned VW     = NCHUNK * CHW;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MIX   = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [VW-1:0]  shreg_q, shreg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CHW-1:0] mix_sel_q, mix_sel_d;
  logic           blk_ready_q, blk_ready_d;
  logic           mix_en_q, mix_en_d;
  logic           round_req_q, round_req_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           abort_c;

`ifdef MIX_CTRL_ABORT_EN
  assign abort_c = bus.abort;
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_c      = 1'b0;
`endif

  // Next state plus output decode of the state being entered, so outputs register with it.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    mix_sel_d   = mix_sel_q;
    blk_ready_d = 1'b0;
    mix_en_d    = 1'b0;
    round_req_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.blk_valid && blk_ready_q) begin
          shreg_d = VW'({bus.blk_ds, bus.blk_data});
          idx_d   = '0;
          state_d = MIX;
        end
      end
      MIX: begin
        state_d = (idx_q == LAST_IDX) ? DONE : RWAIT;
      end
      RWAIT: begin
        if (bus.round_ack) begin
          shreg_d = shreg_q >> CHW;
          idx_d   = idx_q + IW'(1);
          state_d = MIX;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort dominates a same-cycle round_ack.
    if (abort_c && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
    end

    case (state_d)
      IDLE: begin
        blk_ready_d = 1'b1;
      end
      MIX: begin
        mix_en_d  = 1'b1;
        busy_d    = 1'b1;
        mix_sel_d = shreg_d[CHW-1:0];
      end
      RWAIT: begin
        round_req_d = 1'b1;
        busy_d      = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        blk_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      mix_sel_q   <= '0;
      blk_ready_q <= 1'b1;
      mix_en_q    <= 1'b0;
      round_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      mix_sel_q   <= mix_sel_d;
      blk_ready_q <= blk_ready_d;
      mix_en_q    <= mix_en_d;
      round_req_q <= round_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.mix_d     = mix_sel_q;
  assign bus.mix_en    = mix_en_q;
  assign bus.round_req = round_req_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.chunk_idx = idx_q;
endmodule

// File: tb/tb_drysponge_mix_ctrl.sv
// Self-checking bench for drysponge_mix_ctrl: random blocks and round-ack delays
// checked against a chunk/latency model derived from the block layout.
module tb_drysponge_mix_ctrl;
  localparam int CW         = 5;
  localparam int BLOCK_BITS = 128;
  localparam int DS_BITS    = 4;
  localparam int CHW        = 2 * CW;
  localparam int NCHUNK     = (BLOCK_BITS + DS_BITS + CHW - 1) / CHW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drysponge_mix_ctrl_if #(.CW(CW), .BLOCK_BITS(BLOCK_BITS), .DS_BITS(DS_BITS)) bus ();

  drysponge_mix_ctrl #(.CW(CW), .BLOCK_BITS(BLOCK_BITS), .DS_BITS(DS_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Per-round ack delay (cycles round_req is held before ack) used by the model.
  int dly [NCHUNK];

  // Observations of the most recent run_block call.
  logic [CHW-1:0] obs_mix [32];
  int             obs_mt  [32];
  int             obs_idx [32];
  int             obs_n, obs_req, obs_done_t, obs_ready_during, obs_stable_bad, obs_wait;
  logic           obs_ready_after, obs_busy_after, obs_done_after, obs_busy_first;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Chunk k of V = {zero pad, ds, data}, built bit by bit from the layout.
  function automatic logic [CHW-1:0] exp_chunk(input logic [BLOCK_BITS-1:0] d,
                                               input logic [DS_BITS-1:0] s, input int k);
    logic [CHW-1:0] r;
    int i;
    r = '0;
    for (int b = 0; b < CHW; b++) begin
      i = CHW * k + b;
      if (i < BLOCK_BITS)                r[b] = d[i];
      else if (i < BLOCK_BITS + DS_BITS) r[b] = s[i - BLOCK_BITS];
    end
    return r;
  endfunction

  // Cycle (relative to the accept cycle T) of the k-th mix strobe.
  function automatic int exp_t(input int k);
    int t;
    t = 1;
    for (int j = 0; j < k; j++) t += 2 + dly[j];
    return t;
  endfunction

  function automatic int exp_done();
    int t;
    t = 2 * NCHUNK;
    for (int j = 0; j < NCHUNK - 1; j++) t += dly[j];
    return t;
  endfunction

  function automatic int exp_req();
    int n;
    n = 0;
    for (int j = 0; j < NCHUNK - 1; j++) n += dly[j] + 1;
    return n;
  endfunction

  // Offers one block and plays the round engine; ack_idle: value of round_ack while
  // no round is requested (0, 1, or 2 = random noise).
  task automatic run_block(input logic [BLOCK_BITS-1:0] d, input logic [DS_BITS-1:0] s,
                           input int ack_idle, input bit hold_valid);
    int t, rnd, cnt, budget;
    logic [CHW-1:0] last_mix;
    obs_n = 0; obs_req = 0; obs_done_t = -1; obs_ready_during = 0;
    obs_stable_bad = 0; obs_wait = 0;
    for (int i = 0; i < 32; i++) begin obs_mix[i] = '0; obs_mt[i] = -1; obs_idx[i] = -1; end
    bus.abort = 1'b0;
    while (bus.blk_ready !== 1'b1 && obs_wait < 64) begin
      bus.blk_valid = 1'b0;
      step();
      obs_wait++;
    end
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_ds    = s;
    bus.round_ack = (ack_idle == 1) ? 1'b1 : 1'b0;
    step();
    obs_busy_first = bus.busy;
    rnd = 0; cnt = 0; last_mix = '0;
    budget = exp_done() + 8;
    for (t = 1; t <= budget; t++) begin
      if (!hold_valid) bus.blk_valid = 1'b0;
      if (bus.mix_en === 1'b1 && obs_n < 32) begin
        obs_mix[obs_n] = bus.mix_d;
        obs_mt[obs_n]  = t;
        obs_idx[obs_n] = int'(bus.chunk_idx);
        obs_n++;
        last_mix = bus.mix_d;
      end
      if (bus.blk_ready === 1'b1) obs_ready_during++;
      if (bus.round_req === 1'b1) begin
        obs_req++;
        if (bus.mix_d !== last_mix) obs_stable_bad++;
        if (cnt >= dly[rnd]) begin
          bus.round_ack = 1'b1;
          cnt = 0;
          if (rnd < NCHUNK - 1) rnd++;
        end else begin
          bus.round_ack = 1'b0;
          cnt++;
        end
      end else begin
        bus.round_ack = (ack_idle == 2) ? 1'($urandom()) : 1'(ack_idle);
      end
      if (bus.done === 1'b1) begin
        obs_done_t = t;
        break;
      end
      step();
    end
    step();
    obs_ready_after = bus.blk_ready;
    obs_busy_after  = bus.busy;
    obs_done_after  = bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests++;
    if ({bus.blk_ready, bus.mix_en, bus.round_req, bus.done, bus.busy} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy/mix/req/done/busy=%b want 10000",
               {bus.blk_ready, bus.mix_en, bus.round_req, bus.done, bus.busy});
    end
    tests++;
    if (bus.chunk_idx !== '0 || bus.mix_d !== '0) begin
      fails++;
      $display("FAIL reset_regs: got chunk_idx=%0d mix_d=%h want 0/000", bus.chunk_idx, bus.mix_d);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got blk_ready=%b busy=%b want 1/0", bus.blk_ready, bus.busy);
    end
  endtask

  task automatic test_mix_sequence();
    logic [BLOCK_BITS-1:0] d;
    logic [DS_BITS-1:0]    s;
    for (int sc = 0; sc < 5; sc++) begin
      if (sc == 0) begin
        d = '0; s = '0;
      end else begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        s = DS_BITS'($urandom());
      end
      for (int j = 0; j < NCHUNK; j++) dly[j] = (sc == 0) ? 0 : int'($urandom_range(0, 3));
      run_block(d, s, (sc == 0) ? 1 : 2, 1'b0);
      tests++;
      if (obs_n !== NCHUNK) begin
        fails++;
        $display("FAIL seq%0d_mix_count: got %0d want %0d", sc, obs_n, NCHUNK);
      end
      for (int k = 0; k < NCHUNK; k++) begin
        tests++;
        if (obs_mix[k] !== exp_chunk(d, s, k) || obs_mt[k] !== exp_t(k) || obs_idx[k] !== k) begin
          fails++;
          $display("FAIL seq%0d_chunk%0d: got mix_d=%h t=%0d idx=%0d want mix_d=%h t=%0d idx=%0d",
                   sc, k, obs_mix[k], obs_mt[k], obs_idx[k], exp_chunk(d, s, k), exp_t(k), k);
        end
      end
      tests++;
      if (obs_done_t !== exp_done() || (sc == 0 && obs_done_t !== 28)) begin
        fails++;
        $display("FAIL seq%0d_done_time: got T+%0d want T+%0d", sc, obs_done_t, exp_done());
      end
      tests++;
      if (obs_req !== exp_req()) begin
        fails++;
        $display("FAIL seq%0d_round_cycles: got %0d want %0d", sc, obs_req, exp_req());
      end
      tests++;
      if (obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0 ||
          obs_ready_during !== 0 || obs_stable_bad !== 0 || obs_busy_first !== 1'b1) begin
        fails++;
        $display("FAIL seq%0d_handshake: got rdy_after=%b busy_after=%b done_after=%b rdy_busy=%0d unstable=%0d busy1=%b want 1 0 0 0 0 1",
                 sc, obs_ready_after, obs_busy_after, obs_done_after, obs_ready_during,
                 obs_stable_bad, obs_busy_first);
      end
    end
  endtask

  task automatic test_pattern();
    int bad;
    for (int j = 0; j < NCHUNK; j++) dly[j] = 0;
    run_block(128'h3FF, 4'hA, 1, 1'b0);
    tests++;
    if (obs_mix[0] !== 10'h3FF) begin
      fails++;
      $display("FAIL pattern_chunk0: got %h want 3ff", obs_mix[0]);
    end
    bad = 0;
    for (int k = 1; k < 12; k++) if (obs_mix[k] !== 10'h000 || obs_mt[k] < 0) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL pattern_mid_zero: got %0d nonzero/missing chunks want 0", bad);
    end
    tests++;
    if (obs_mix[12] !== 10'h200 || obs_mix[13] !== 10'h002) begin
      fails++;
      $display("FAIL pattern_ds_chunks: got %h %h want 200 002", obs_mix[12], obs_mix[13]);
    end
  endtask

  task automatic test_ack_delay();
    logic [BLOCK_BITS-1:0] d;
    int bad;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int j = 0; j < NCHUNK; j++) dly[j] = 3;
    run_block(d, 4'h5, 0, 1'b0);
    tests++;
    if (obs_done_t !== 28 + 13 * 3) begin
      fails++;
      $display("FAIL delay_done_time: got T+%0d want T+%0d", obs_done_t, 28 + 13 * 3);
    end
    tests++;
    if (obs_req !== 13 * 4 || obs_stable_bad !== 0) begin
      fails++;
      $display("FAIL delay_req_hold: got req_cycles=%0d unstable=%0d want 52/0", obs_req, obs_stable_bad);
    end
    bad = 0;
    for (int k = 0; k < NCHUNK; k++)
      if (obs_mix[k] !== exp_chunk(d, 4'h5, k) || obs_mt[k] !== exp_t(k)) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL delay_chunks: got %0d wrong chunks want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [BLOCK_BITS-1:0] d;
    logic [DS_BITS-1:0]    s;
    int bad;
    for (int j = 0; j < NCHUNK; j++) dly[j] = 0;
    for (int b = 0; b < 2; b++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      s = DS_BITS'($urandom());
      run_block(d, s, 2, 1'b1);
      tests++;
      if ((b == 1 && obs_wait !== 0) || obs_done_t !== 28 || obs_ready_during !== 0 ||
          obs_ready_after !== 1'b1) begin
        fails++;
        $display("FAIL b2b%0d_accept: got wait=%0d done=T+%0d rdy_busy=%0d rdy_after=%b want 0 28 0 1",
                 b, obs_wait, obs_done_t, obs_ready_during, obs_ready_after);
      end
      bad = 0;
      for (int k = 0; k < NCHUNK; k++) if (obs_mix[k] !== exp_chunk(d, s, k)) bad++;
      tests++;
      if (bad !== 0 || obs_n !== NCHUNK) begin
        fails++;
        $display("FAIL b2b%0d_chunks: got %0d wrong of %0d seen want 0 of %0d", b, bad, obs_n, NCHUNK);
      end
    end
    bus.blk_valid = 1'b0;
    step();
    tests++;
    if (bus.busy !== 1'b0 || bus.blk_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle: got busy=%b blk_ready=%b want 0/1", bus.busy, bus.blk_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [BLOCK_BITS-1:0] d;
    bit hit;
    int ndone;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.abort = 1'b0; bus.round_ack = 1'b0;
    bus.blk_data = d; bus.blk_ds = 4'h3; bus.blk_valid = 1'b1;
    step();
    bus.blk_valid = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      if (bus.round_req === 1'b1 && int'(bus.chunk_idx) == 5) hit = 1'b1;
      else begin
        bus.round_ack = bus.round_req;
        step();
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL rstmid_reach: got no RWAIT at chunk_idx=5 want one within 40 cycles");
    end
    bus.round_ack = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if ({bus.round_req, bus.busy, bus.blk_ready, bus.done, bus.mix_en} !== 5'b00100 ||
        bus.chunk_idx !== '0) begin
      fails++;
      $display("FAIL rstmid_state: got req/busy/rdy/done/mix=%b idx=%0d want 00100 idx=0",
               {bus.round_req, bus.busy, bus.blk_ready, bus.done, bus.mix_en}, bus.chunk_idx);
    end
    ndone = 0;
    for (int t = 0; t < 35; t++) begin
      bus.round_ack = 1'($urandom());
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      step();
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL rstmid_no_done: got %0d done/busy cycles want 0", ndone);
    end
    for (int j = 0; j < NCHUNK; j++) dly[j] = 0;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(d, 4'hC, 0, 1'b0);
    tests++;
    if (obs_done_t !== 28 || obs_n !== NCHUNK || obs_mix[NCHUNK-1] !== exp_chunk(d, 4'hC, NCHUNK - 1)) begin
      fails++;
      $display("FAIL rstmid_fresh: got done=T+%0d mixes=%0d last=%h want 28 14 %h",
               obs_done_t, obs_n, obs_mix[NCHUNK-1], exp_chunk(d, 4'hC, NCHUNK - 1));
    end
  endtask

  task automatic test_abort();
    int nmix, t, ndone;
    bus.abort = 1'b0; bus.round_ack = 1'b0;
    bus.blk_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.blk_ds = 4'h9; bus.blk_valid = 1'b1;
    step();
    bus.blk_valid = 1'b0;
    nmix = 0;
    t = 1;
    while (t < 20) begin
      if (bus.mix_en === 1'b1) nmix++;
      if (nmix == 3) break;
      bus.round_ack = bus.round_req;
      step();
      t++;
    end
    tests++;
    if (nmix !== 3 || t !== 5) begin
      fails++;
      $display("FAIL abort_third_mix: got %0d mixes by T+%0d want 3 by T+5", nmix, t);
    end
    bus.abort = 1'b1;
    bus.round_ack = 1'b1;
    step();
    bus.abort = 1'b0;
    t++;
`ifdef MIX_CTRL_ABORT_EN
    tests++;
    if ({bus.round_req, bus.mix_en, bus.busy, bus.blk_ready, bus.done} !== 5'b00010 ||
        bus.chunk_idx !== '0) begin
      fails++;
      $display("FAIL abort_idle: got req/mix/busy/rdy/done=%b idx=%0d want 00010 idx=0",
               {bus.round_req, bus.mix_en, bus.busy, bus.blk_ready, bus.done}, bus.chunk_idx);
    end
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      if (bus.done === 1'b1) ndone++;
      bus.round_ack = 1'($urandom());
      step();
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
    end
`else
    ndone = -1;
    while (t < 60) begin
      if (bus.done === 1'b1) begin
        ndone = t;
        break;
      end
      bus.round_ack = bus.round_req;
      step();
      t++;
    end
    tests++;
    if (ndone !== 28) begin
      fails++;
      $display("FAIL abort_ignored: got done at T+%0d want T+28", ndone);
    end
`endif
  endtask

  initial begin
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_ds    = '0;
    bus.round_ack = 1'b0;
    bus.abort     = 1'b0;
    for (int j = 0; j < NCHUNK; j++) dly[j] = 0;
    test_reset();
    test_mix_sequence();
    test_pattern();
    test_ack_delay();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
